// File: rtl/alu_pkg.sv
// Constants and tag type shared between the ALU core and the blocks that feed it.
package alu_pkg;

  localparam int ALU_DW      = 8;
  localparam int ALU_OW      = 16;
  localparam int ALU_IW      = 3;
  localparam int ALU_LAT_DEF = 2;

  typedef struct packed {
    logic       vld;
    logic [1:0] id;
  } tag_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational wrap-around priority picker: first valid requester after ptr,
// ptr itself is searched last. Returns a one-hot grant, zero when nothing is valid.
module alu_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (ptr == 2'(p)) begin
        for (int off = 1; off <= NUM_REQ; off++) begin
          if (!found && valid[(p + off) % NUM_REQ]) begin
            grant[(p + off) % NUM_REQ] = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one pipelined ALU between up to four requesters: round-robin grant with
// bounded lock bursts, operand issue, and tagged in-order routing of results.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ALU_LAT   = ALU_LAT_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk_p_i,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  input  logic [ALU_DW*NUM_REQ-1:0] req_a_i,
  input  logic [ALU_DW*NUM_REQ-1:0] req_b_i,
  input  logic [ALU_IW*NUM_REQ-1:0] req_inst_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [ALU_DW-1:0]         alu_a_o,
  output logic [ALU_DW-1:0]         alu_b_o,
  output logic [ALU_IW-1:0]         alu_inst_o,
  input  logic [ALU_OW-1:0]         alu_data_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [ALU_OW-1:0]         resp_data_o,
  output logic                      busy_o
);

  // The core registers its inputs one edge after issue, then takes ALU_LAT
  // cycles; the extra tag stage keeps the tag aligned with alu_data_i.
  localparam int TAG_DEPTH = ALU_LAT + 2;

  logic [1:0]                rr_ptr_reg;
  logic [NUM_REQ-1:0]        owner_oh_reg;
  logic [3:0]                burst_cnt_reg;
  logic [3:0]                burst_cnt_next;
  logic                      xfer_prev_reg;
  tag_t [TAG_DEPTH-1:0]      tag_reg;
  tag_t                      tag_next;

  logic [NUM_REQ-1:0]        pick;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        resp_valid_next;
  logic                      keep;
  logic                      xfer;
  logic [1:0]                grant_id;
  logic [ALU_DW-1:0]         a_sel;
  logic [ALU_DW-1:0]         b_sel;
  logic [ALU_IW-1:0]         inst_sel;
  logic [ALU_DW-1:0]         a_arr    [NUM_REQ];
  logic [ALU_DW-1:0]         b_arr    [NUM_REQ];
  logic [ALU_IW-1:0]         inst_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]    = req_a_i[ALU_DW*gi +: ALU_DW];
      assign b_arr[gi]    = req_b_i[ALU_DW*gi +: ALU_DW];
      assign inst_arr[gi] = req_inst_i[ALU_IW*gi +: ALU_IW];
    end
  endgenerate

  alu_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (req_valid_i),
    .ptr   (rr_ptr_reg),
    .grant (pick)
  );

  // The last owner keeps the grant only while it is locked, still valid,
  // was served last cycle and has not used up its burst allowance.
  assign keep = xfer_prev_reg && (|(req_valid_i & req_lock_i & owner_oh_reg)) &&
                (burst_cnt_reg < 4'(MAX_BURST));
  assign grant       = keep ? owner_oh_reg : pick;
  assign req_ready_o = grant & {NUM_REQ{reset_n_i}};
  assign xfer        = |(req_valid_i & req_ready_o);

  always_comb begin
    grant_id = '0;
    a_sel    = '0;
    b_sel    = '0;
    inst_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = 2'(i);
        a_sel    = a_arr[i];
        b_sel    = b_arr[i];
        inst_sel = inst_arr[i];
      end
    end
  end

  always_comb begin
    burst_cnt_next = 4'd1;
    if (xfer_prev_reg && (grant_id == rr_ptr_reg)) begin
      burst_cnt_next = (burst_cnt_reg >= 4'(MAX_BURST)) ? 4'(MAX_BURST) : burst_cnt_reg + 4'd1;
    end
  end

  assign tag_next.vld = xfer;
  assign tag_next.id  = grant_id;

  always_comb begin
    resp_valid_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_next[i] = tag_reg[TAG_DEPTH-1].vld && (tag_reg[TAG_DEPTH-1].id == 2'(i));
    end
  end

  always_comb begin
    busy_o = |resp_valid_o;
    for (int s = 0; s < TAG_DEPTH; s++) begin
      busy_o = busy_o | tag_reg[s].vld;
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_reg    <= 2'(NUM_REQ - 1);
      owner_oh_reg  <= '0;
      burst_cnt_reg <= '0;
      xfer_prev_reg <= 1'b0;
      tag_reg       <= '0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      alu_inst_o    <= '0;
      resp_valid_o  <= '0;
      resp_data_o   <= '0;
    end else begin
      xfer_prev_reg <= xfer;
      tag_reg       <= {tag_reg[TAG_DEPTH-2:0], tag_next};
      resp_valid_o  <= resp_valid_next;
      if (tag_reg[TAG_DEPTH-1].vld) begin
        resp_data_o <= alu_data_i;
      end
      if (xfer) begin
        rr_ptr_reg    <= grant_id;
        owner_oh_reg  <= grant;
        burst_cnt_reg <= burst_cnt_next;
        alu_a_o       <= a_sel;
        alu_b_o       <= b_sel;
        alu_inst_o    <= inst_sel;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: arbitration table, directed corner sequences and random
// traffic, all scored against a queue-based reference model of the sharing rules.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NR  = 3;
  localparam int LAT = 2;
  localparam int MB  = 4;
  localparam int E2E = LAT + 2;

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] l;
    logic [NR-1:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] d;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NR-1:0] tvalid;
  logic [NR-1:0] tlock;
  logic [7:0]    ta   [NR];
  logic [7:0]    tb_b [NR];
  logic [2:0]    ti   [NR];

  logic [8*NR-1:0] req_a;
  logic [8*NR-1:0] req_b;
  logic [3*NR-1:0] req_inst;
  logic [NR-1:0]   req_ready;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [2:0]      alu_inst;
  logic [15:0]     alu_data;
  logic [NR-1:0]   resp_valid;
  logic [15:0]     resp_data;
  logic            busy;

  // Behavioural ALU stand-in: input register plus a 2-cycle pipe returning {a,b}.
  logic [15:0] alu_p0, alu_p1, alu_p2;

  int          checks = 0;
  int          errors = 0;
  int          m_ptr, m_cnt, m_cyc;
  bit          m_prev;
  logic [15:0] m_last_data;
  logic [7:0]  m_a, m_b;
  logic [2:0]  m_i;
  exp_t        q[$];
  vec_t        tbl[13];

  int            g, acc, t0;
  bit            seen, any_resp;
  logic [NR-1:0] rdy, rdy_last;

  always #5 clk = ~clk;

  assign req_a    = {ta[2], ta[1], ta[0]};
  assign req_b    = {tb_b[2], tb_b[1], tb_b[0]};
  assign req_inst = {ti[2], ti[1], ti[0]};

  always @(posedge clk) begin
    alu_p0 <= {alu_a, alu_b};
    alu_p1 <= alu_p0;
    alu_p2 <= alu_p1;
  end
  assign alu_data = alu_p2;

  alu_share_ctrl #(.NUM_REQ(NR), .ALU_LAT(LAT), .MAX_BURST(MB)) dut (
    .clk_p_i      (clk),
    .reset_n_i    (reset_n),
    .req_valid_i  (tvalid),
    .req_lock_i   (tlock),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_inst_i   (req_inst),
    .req_ready_o  (req_ready),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_inst_o   (alu_inst),
    .alu_data_i   (alu_data),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .busy_o       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = NR - 1;
    m_cnt = 0;
    m_prev = 1'b0;
    m_cyc = 0;
    m_last_data = '0;
    m_a = '0;
    m_b = '0;
    m_i = '0;
    q.delete();
  endtask

  // Owner keeps the slot while locked, valid, just served and under the burst cap;
  // otherwise the next valid index after the last grant, wrapping around.
  function automatic int model_pick();
    if (m_prev && tvalid[m_ptr] && tlock[m_ptr] && m_cnt < MB) return m_ptr;
    for (int k = 1; k <= NR; k++) begin
      if (tvalid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic cycle(output int gi, output logic [NR-1:0] rd);
    logic [NR-1:0] exp_v;
    exp_t e;
    #1;
    gi = model_pick();
    rd = req_ready;
    chk("ready", 32'(req_ready), (gi >= 0) ? (32'd1 << gi) : 32'd0);
    @(posedge clk);
    #1;
    m_cyc++;
    if (gi >= 0) begin
      m_cnt = (m_prev && gi == m_ptr) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
      m_ptr = gi;
      m_a = ta[gi];
      m_b = tb_b[gi];
      m_i = ti[gi];
      e.id = gi;
      e.d = {ta[gi], tb_b[gi]};
      e.due = m_cyc + E2E;
      q.push_back(e);
      $display("xfer t=%0d req=%0d a=%02h b=%02h inst=%0d", m_cyc, gi, ta[gi], tb_b[gi], ti[gi]);
    end
    m_prev = (gi >= 0);
    exp_v = '0;
    if (q.size() > 0 && q[0].due == m_cyc) begin
      e = q.pop_front();
      exp_v = NR'(1 << e.id);
      m_last_data = e.d;
    end
    chk("resp_valid", 32'(resp_valid), 32'(exp_v));
    chk("resp_data", 32'(resp_data), 32'(m_last_data));
    chk("busy", 32'(busy), 32'((q.size() > 0) || (exp_v != '0)));
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("alu_inst", 32'(alu_inst), 32'(m_i));
    if (gi >= 0) begin
      ta[gi] = 8'($urandom_range(0, 127));
      tb_b[gi] = 8'($urandom);
      ti[gi] = 3'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tvalid = '0;
    tlock = '0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_inst", 32'(alu_inst), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_resp_valid", 32'(resp_valid), 32'd0);
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b1;
    tvalid = '0;
    tlock = '0;
    rdy_last = '0;
    for (int r = 0; r < NR; r++) begin
      ta[r] = 8'(r + 1);
      tb_b[r] = 8'(r + 32);
      ti[r] = 3'(r);
    end
    // {valid, lock, expected ready}: lock burst on req1, then plain contention.
    tbl[0]  = '{3'b010, 3'b010, 3'b010};
    tbl[1]  = '{3'b011, 3'b010, 3'b010};
    tbl[2]  = '{3'b011, 3'b010, 3'b010};
    tbl[3]  = '{3'b011, 3'b010, 3'b010};
    tbl[4]  = '{3'b011, 3'b010, 3'b001};
    tbl[5]  = '{3'b011, 3'b010, 3'b010};
    tbl[6]  = '{3'b011, 3'b010, 3'b010};
    tbl[7]  = '{3'b011, 3'b000, 3'b001};
    tbl[8]  = '{3'b011, 3'b000, 3'b010};
    tbl[9]  = '{3'b011, 3'b000, 3'b001};
    tbl[10] = '{3'b011, 3'b000, 3'b010};
    tbl[11] = '{3'b001, 3'b000, 3'b001};
    tbl[12] = '{3'b000, 3'b000, 3'b000};
    #2;
    do_reset();

    for (int k = 0; k < 13; k++) begin
      tvalid = tbl[k].v;
      tlock = tbl[k].l;
      #1;
      chk($sformatf("tbl%0d_ready", k), 32'(req_ready), 32'(tbl[k].exp));
      cycle(g, rdy);
    end
    repeat (6) cycle(g, rdy);

    // Single request, end-to-end latency and data.
    do_reset();
    ta[0] = 8'h12;
    tb_b[0] = 8'h34;
    ti[0] = 3'd5;
    tvalid = 3'b001;
    cycle(g, rdy);
    chk("single_accept", 32'(rdy), 32'd1);
    t0 = m_cyc;
    tvalid = '0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle(g, rdy);
      if (resp_valid[0]) begin
        seen = 1'b1;
        chk("single_lat", 32'(m_cyc - t0), 32'(E2E));
        chk("single_data", 32'(resp_data), 32'h1234);
      end
    end
    chk("single_seen", 32'(seen), 32'd1);
    repeat (3) cycle(g, rdy);

    // Lone locked requester keeps being served with no bubbles.
    do_reset();
    tvalid = 3'b100;
    tlock = 3'b100;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(g, rdy);
      if (rdy[2]) acc++;
    end
    chk("lone_accepts", 32'(acc), 32'd10);
    tvalid = '0;
    repeat (6) cycle(g, rdy);

    // Reset while three operations are in flight.
    do_reset();
    tvalid = 3'b011;
    repeat (3) cycle(g, rdy);
    do_reset();
    any_resp = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle(g, rdy);
      any_resp = any_resp | (|resp_valid);
    end
    chk("post_rst_quiet", 32'(any_resp), 32'd0);

    // req0 waits while locked req1 bursts; its operands must not reach the ALU.
    do_reset();
    tvalid = 3'b010;
    tlock = 3'b010;
    cycle(g, rdy);
    ta[0] = 8'hA0;
    tb_b[0] = 8'h55;
    tvalid = 3'b011;
    for (int k = 0; k < 3; k++) begin
      cycle(g, rdy);
      chk("hold_rdy0", 32'(rdy[0]), 32'd0);
      chk("hold_no_a0", 32'(alu_a == 8'hA0), 32'd0);
    end
    cycle(g, rdy);
    chk("hold_take_rdy0", 32'(rdy[0]), 32'd1);
    chk("hold_take_a", 32'(alu_a), 32'hA0);
    cycle(g, rdy);
    tvalid = '0;
    tlock = '0;
    repeat (6) cycle(g, rdy);

    // Random traffic: pending requests stay valid until accepted.
    do_reset();
    rdy_last = '0;
    for (int k = 0; k < 400; k++) begin
      for (int r = 0; r < NR; r++) begin
        if (!tvalid[r] || rdy_last[r]) tvalid[r] = ($urandom_range(0, 2) != 0);
        tlock[r] = ($urandom_range(0, 2) != 0);
      end
      cycle(g, rdy);
      rdy_last = rdy;
    end
    tvalid = '0;
    repeat (8) cycle(g, rdy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
